// File: rtl/msx_bus_pkg.sv
// msx_bus_pkg: shared FSM encoding and mapper constants for the MSX PSRAM bridge
package msx_bus_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_ACK, ST_WAIT, ST_HOLD, ST_IO_RD} state_t;
  localparam logic [3:0][7:0] MAPPER_RST = {8'd0, 8'd1, 8'd2, 8'd3};
  localparam logic [7:0] IO_BASE_DEFAULT = 8'hFC;
  localparam int PSRAM_FREQ = 72_000_000;
  localparam int PSRAM_LATENCY = 3;
endpackage

// File: rtl/msx_mapper_regs.sv
// msx_mapper_regs: four segment registers with edge-detected I/O write and padded readback
import msx_bus_pkg::*;
module msx_mapper_regs #(
  parameter int SEG_BITS = 8,
  parameter int MAP_BITS = 8
) (
  input  logic                  clk_72m,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [SEG_BITS-1:0]   wr_data,
  input  logic [1:0]            rd_sel,
  output logic [7:0]            rd_data,
  input  logic [1:0]            map_sel,
  output logic [MAP_BITS-1:0]   map_seg,
  output logic [4*SEG_BITS-1:0] seg_reg
);
  logic [SEG_BITS-1:0] r [4];
  logic                wr_q;
  // one register update on the rising edge of each I/O write cycle
  always_ff @(posedge clk_72m) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r[i] <= MAPPER_RST[i][SEG_BITS-1:0];
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_en;
      if (wr_en && !wr_q) r[wr_sel] <= wr_data;
    end
  end
  generate
    if (SEG_BITS < 8) begin : g_pad
      assign rd_data = {{(8-SEG_BITS){1'b1}}, r[rd_sel]};
    end else begin : g_full
      assign rd_data = r[rd_sel][7:0];
    end
  endgenerate
  assign map_seg = r[map_sel][MAP_BITS-1:0];
  assign seg_reg = {r[3], r[2], r[1], r[0]};
endmodule

// File: rtl/msx_mapper_psram_bridge.sv
// msx_mapper_psram_bridge: MSX memory mapper translating slot cycles into PSRAM byte requests
import msx_bus_pkg::*;
module msx_mapper_psram_bridge #(
  parameter int         ADDR_BITS   = 22,
  parameter int         SEG_BITS    = 8,
  parameter logic [7:0] IO_BASE     = IO_BASE_DEFAULT,
  parameter bit         READBACK_EN = 1'b1
) (
  input  logic                  clk_72m,
  input  logic                  reset,
  input  logic [15:0]           bus_addr,
  input  logic [7:0]            bus_din,
  input  logic                  bus_mreq_n,
  input  logic                  bus_iorq_n,
  input  logic                  bus_rd_n,
  input  logic                  bus_wr_n,
  input  logic                  bus_sltsl_n,
  input  logic                  bus_rfsh_n,
  output logic [7:0]            bus_dout,
  output logic                  bus_data_oe,
  output logic                  psram_read,
  output logic                  psram_write,
  output logic [ADDR_BITS-1:0]  psram_addr,
  output logic [15:0]           psram_din,
  input  logic [15:0]           psram_dout,
  input  logic                  psram_busy,
  output logic [4*SEG_BITS-1:0] seg_reg,
  output logic                  access_pulse
);
  localparam int MAP_BITS = ADDR_BITS - 14;
  state_t              state;
  logic                mem_rd, mem_wr, io_sel, is_wr;
  logic [15:0]         addr_q;
  logic [7:0]          data_q, rb_data;
  logic [MAP_BITS-1:0] map_seg;
  // bus cycle decode; refresh cycles never qualify as memory accesses
  always_comb begin
    mem_rd = !bus_mreq_n && !bus_rd_n && !bus_sltsl_n && bus_rfsh_n;
    mem_wr = !bus_mreq_n && !bus_wr_n && !bus_sltsl_n && bus_rfsh_n;
    io_sel = !bus_iorq_n && (bus_addr[7:2] == IO_BASE[7:2]);
  end
  msx_mapper_regs #(.SEG_BITS(SEG_BITS), .MAP_BITS(MAP_BITS)) u_regs (
    .clk_72m (clk_72m),
    .reset   (reset),
    .wr_en   (io_sel && !bus_wr_n),
    .wr_sel  (bus_addr[1:0]),
    .wr_data (bus_din[SEG_BITS-1:0]),
    .rd_sel  (addr_q[1:0]),
    .rd_data (rb_data),
    .map_sel (addr_q[15:14]),
    .map_seg (map_seg),
    .seg_reg (seg_reg)
  );
  // bridge FSM: one PSRAM request per Z80 cycle, bus drive held until the cycle ends
  always_ff @(posedge clk_72m) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      is_wr        <= 1'b0;
      bus_dout     <= '0;
      bus_data_oe  <= 1'b0;
      psram_read   <= 1'b0;
      psram_write  <= 1'b0;
      psram_addr   <= '0;
      psram_din    <= '0;
      access_pulse <= 1'b0;
    end else begin
      psram_read   <= 1'b0;
      psram_write  <= 1'b0;
      access_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          addr_q      <= bus_addr;
          data_q      <= bus_din;
          is_wr       <= mem_wr;
          bus_data_oe <= 1'b0;
          if (mem_wr || mem_rd) state <= ST_ISSUE;
          else if (io_sel && !bus_rd_n && READBACK_EN) state <= ST_IO_RD;
        end
        ST_ISSUE: if (!psram_busy) begin
          psram_addr   <= {map_seg, addr_q[13:0]};
          psram_din    <= {data_q, data_q};
          psram_write  <= is_wr;
          psram_read   <= !is_wr;
          access_pulse <= 1'b1;
          state        <= ST_ACK;
        end
        ST_ACK: state <= ST_WAIT;
        ST_WAIT: if (!psram_busy) begin
          if (!is_wr) begin
            bus_dout    <= addr_q[0] ? psram_dout[15:8] : psram_dout[7:0];
            bus_data_oe <= 1'b1;
          end
          state <= ST_HOLD;
        end
        ST_HOLD: if (!mem_rd && !mem_wr) begin
          bus_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
        ST_IO_RD: if (bus_rd_n || bus_iorq_n) begin
          bus_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end else begin
          bus_dout    <= rb_data;
          bus_data_oe <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msx_mapper_psram_bridge.sv
// tb_msx_mapper_psram_bridge: randomized checks of three mapper configurations against a register model
module tb_msx_mapper_psram_bridge;
  logic        clk_72m = 1'b0;
  logic        reset;
  logic [15:0] bus_addr, psram_dout;
  logic [7:0]  bus_din;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_sltsl_n, bus_rfsh_n, psram_busy;
  logic [7:0]  a_dout, b_dout, c_dout;
  logic        a_oe, b_oe, c_oe, a_rd, b_rd, c_rd, a_wr, b_wr, c_wr, a_acc, b_acc, c_acc;
  logic [21:0] a_addr;
  logic [19:0] b_addr, c_addr;
  logic [15:0] a_din, b_din, c_din;
  logic [31:0] a_seg, c_seg;
  logic [23:0] b_seg;
  int          checks = 0, errors = 0;
  int          mreg [4];

  always #5 clk_72m = ~clk_72m;

  msx_mapper_psram_bridge dut_a (
    .clk_72m(clk_72m), .reset(reset), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_sltsl_n(bus_sltsl_n), .bus_rfsh_n(bus_rfsh_n), .bus_dout(a_dout), .bus_data_oe(a_oe),
    .psram_read(a_rd), .psram_write(a_wr), .psram_addr(a_addr), .psram_din(a_din),
    .psram_dout(psram_dout), .psram_busy(psram_busy), .seg_reg(a_seg), .access_pulse(a_acc));

  msx_mapper_psram_bridge #(.ADDR_BITS(20), .SEG_BITS(6), .READBACK_EN(1'b1)) dut_b (
    .clk_72m(clk_72m), .reset(reset), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_sltsl_n(bus_sltsl_n), .bus_rfsh_n(bus_rfsh_n), .bus_dout(b_dout), .bus_data_oe(b_oe),
    .psram_read(b_rd), .psram_write(b_wr), .psram_addr(b_addr), .psram_din(b_din),
    .psram_dout(psram_dout), .psram_busy(psram_busy), .seg_reg(b_seg), .access_pulse(b_acc));

  msx_mapper_psram_bridge #(.ADDR_BITS(20), .SEG_BITS(8), .READBACK_EN(1'b0)) dut_c (
    .clk_72m(clk_72m), .reset(reset), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_sltsl_n(bus_sltsl_n), .bus_rfsh_n(bus_rfsh_n), .bus_dout(c_dout), .bus_data_oe(c_oe),
    .psram_read(c_rd), .psram_write(c_wr), .psram_addr(c_addr), .psram_din(c_din),
    .psram_dout(psram_dout), .psram_busy(psram_busy), .seg_reg(c_seg), .access_pulse(c_acc));

  task automatic bus_idle();
    bus_mreq_n = 1'b1; bus_iorq_n = 1'b1; bus_rd_n = 1'b1;
    bus_wr_n = 1'b1; bus_sltsl_n = 1'b1; bus_rfsh_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({a_oe, b_oe, c_oe, a_rd, a_wr, b_rd, b_wr, c_rd, c_wr, a_acc, b_acc, c_acc} !== 12'd0) begin
      errors++;
      $display("FAIL %s strobes/oe: got %b, expected all zero", name,
               {a_oe, b_oe, c_oe, a_rd, a_wr, b_rd, b_wr, c_rd, c_wr, a_acc, b_acc, c_acc});
    end
  endtask

  task automatic io_write(input int port, input logic [7:0] data);
    logic [1:0] p;
    p = port[1:0];
    @(negedge clk_72m);
    bus_addr = {8'($urandom), 6'b111111, p};
    bus_din = data; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (3) @(negedge clk_72m);
    bus_idle();
    @(negedge clk_72m);
    mreg[port] = int'(data);
  endtask

  task automatic mem_access(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                            input logic [15:0] word, input int pre, input int post);
    int na_r, na_w, nb, nc, nacc, si, oi, bad_oe, ea, eb, es, eo;
    logic [21:0] ca;
    logic [19:0] cb, cc;
    logic [15:0] cdin;
    logic [7:0]  ed;
    na_r = 0; na_w = 0; nb = 0; nc = 0; nacc = 0; si = 0; oi = 0; bad_oe = 0;
    ca = '0; cb = '0; cc = '0; cdin = '0;
    @(negedge clk_72m);
    bus_addr = addr; bus_din = data; psram_dout = word; bus_iorq_n = 1'b1; bus_rfsh_n = 1'b1;
    bus_sltsl_n = 1'b0; bus_mreq_n = 1'b0; bus_rd_n = wr; bus_wr_n = !wr;
    psram_busy = pre > 0;
    for (int i = 1; i <= pre + post + 12; i++) begin
      @(negedge clk_72m);
      if (a_rd || a_wr) begin
        if (si == 0) si = i;
        ca = a_addr; cdin = a_din;
      end
      if (b_rd || b_wr) cb = b_addr;
      if (c_rd || c_wr) cc = c_addr;
      na_r += int'(a_rd); na_w += int'(a_wr); nacc += int'(a_acc);
      nb += int'(b_rd) + int'(b_wr); nc += int'(c_rd) + int'(c_wr);
      if (a_oe && oi == 0) oi = i;
      if (wr && (a_oe || b_oe || c_oe)) bad_oe++;
      if (i == pre) psram_busy = 1'b0;
      if ((a_rd || a_wr) && post > 0) psram_busy = 1'b1;
      if (si > 0 && i == si + post) psram_busy = 1'b0;
    end
    ea = ((mreg[addr[15:14]] % 256) * 16384) + int'(addr[13:0]);
    eb = ((mreg[addr[15:14]] % 64) * 16384) + int'(addr[13:0]);
    ed = addr[0] ? word[15:8] : word[7:0];
    es = pre + 1 > 2 ? pre + 1 : 2;
    eo = post > 1 ? es + post + 1 : es + 2;
    checks++;
    if (na_r != (wr ? 0 : 1) || na_w != (wr ? 1 : 0) || nb != 1 || nc != 1 || nacc != 1) begin
      errors++;
      $display("FAIL req_count: got rd=%0d wr=%0d b=%0d c=%0d pulse=%0d, expected rd=%0d wr=%0d b=1 c=1 pulse=1",
               na_r, na_w, nb, nc, nacc, wr ? 0 : 1, wr ? 1 : 0);
    end
    checks++;
    if (ca !== 22'(ea) || cb !== 20'(eb) || cc !== 20'(eb)) begin
      errors++;
      $display("FAIL psram_addr @%h: got a=%h b=%h c=%h, expected a=%h b=%h c=%h",
               addr, ca, cb, cc, 22'(ea), 20'(eb), 20'(eb));
    end
    checks++;
    if (si != es) begin
      errors++;
      $display("FAIL strobe_latency: got cycle %0d, expected %0d (pre=%0d)", si, es, pre);
    end
    if (wr) begin
      checks++;
      if (cdin !== {data, data} || bad_oe != 0) begin
        errors++;
        $display("FAIL write_data: got din=%h oe_cycles=%0d, expected din=%h oe_cycles=0",
                 cdin, bad_oe, {data, data});
      end
    end else begin
      checks++;
      if (a_oe !== 1'b1 || b_oe !== 1'b1 || c_oe !== 1'b1 || a_dout !== ed || b_dout !== ed || c_dout !== ed) begin
        errors++;
        $display("FAIL read_data @%h: got oe=%b%b%b dout=%h/%h/%h, expected oe=111 dout=%h",
                 addr, a_oe, b_oe, c_oe, a_dout, b_dout, c_dout, ed);
      end
      checks++;
      if (oi != eo) begin
        errors++;
        $display("FAIL read_latency: got cycle %0d, expected %0d (post=%0d)", oi, eo, post);
      end
    end
    bus_idle();
    repeat (2) @(negedge clk_72m);
    check_idle_outputs("mem_release");
  endtask

  task automatic io_read(input int port);
    logic [1:0] p;
    int         c_seen;
    logic [7:0] ea, eb;
    p = port[1:0]; c_seen = 0;
    ea = 8'(mreg[port]);
    eb = 8'hC0 | (ea & 8'h3F);
    @(negedge clk_72m);
    bus_addr = {8'($urandom), 6'b111111, p}; bus_iorq_n = 1'b0; bus_rd_n = 1'b0;
    repeat (5) begin
      @(negedge clk_72m);
      c_seen += int'(c_oe);
    end
    checks++;
    if (a_oe !== 1'b1 || a_dout !== ea) begin
      errors++;
      $display("FAIL readback_a port%0d: got oe=%b dout=%h, expected oe=1 dout=%h", port, a_oe, a_dout, ea);
    end
    checks++;
    if (b_oe !== 1'b1 || b_dout !== eb) begin
      errors++;
      $display("FAIL readback_b port%0d: got oe=%b dout=%h, expected oe=1 dout=%h", port, b_oe, b_dout, eb);
    end
    checks++;
    if (c_seen != 0) begin
      errors++;
      $display("FAIL readback_disabled: got oe high for %0d cycles, expected 0", c_seen);
    end
    bus_idle();
    repeat (2) @(negedge clk_72m);
    check_idle_outputs("io_release");
  endtask

  task automatic check_segs(input string name);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_seg[k*8 +: 8] !== 8'(mreg[k]) || b_seg[k*6 +: 6] !== 6'(mreg[k]) || c_seg[k*8 +: 8] !== 8'(mreg[k])) begin
        errors++;
        $display("FAIL %s reg%0d: got a=%h b=%h c=%h, expected %h", name, k,
                 a_seg[k*8 +: 8], b_seg[k*6 +: 6], c_seg[k*8 +: 8], 8'(mreg[k]));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_idle(); psram_busy = 1'b0; bus_addr = '0; bus_din = '0; psram_dout = '0;
    mreg = '{3, 2, 1, 0};
    repeat (3) @(negedge clk_72m);
    check_idle_outputs("reset");
    checks++;
    if ({a_dout, b_dout, c_dout} !== 24'd0 || a_addr !== 22'd0 || b_addr !== 20'd0 || c_addr !== 20'd0 ||
        {a_din, b_din, c_din} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data: got dout=%h/%h/%h addr=%h/%h/%h din=%h/%h/%h, expected zero",
               a_dout, b_dout, c_dout, a_addr, b_addr, c_addr, a_din, b_din, c_din);
    end
    check_segs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk_72m);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_directed();
    mem_access(1'b0, 16'hC005, 8'h00, 16'hAB12, 0, 2);
    io_write(1, 8'h21);
    check_segs("write_fd");
    mem_access(1'b1, 16'h4001, 8'h5A, 16'($urandom), 0, 3);
    io_write(2, 8'h47);
    mem_access(1'b0, 16'h8000, 8'h00, 16'($urandom), 1, 0);
    io_write(3, 8'h05);
    io_read(3);
  endtask

  task automatic test_busy_init();
    mem_access(1'b1, 16'($urandom), 8'($urandom), 16'($urandom), 500, 2);
  endtask

  task automatic test_edge_write();
    logic [7:0] d0;
    d0 = 8'($urandom);
    @(negedge clk_72m);
    bus_addr = {8'h00, 6'b111111, 2'd2}; bus_din = d0; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (2) @(negedge clk_72m);
    bus_din = ~d0;
    repeat (3) @(negedge clk_72m);
    bus_idle();
    @(negedge clk_72m);
    mreg[2] = int'(d0);
    check_segs("edge_write");
  endtask

  task automatic test_refresh();
    int n;
    n = 0;
    @(negedge clk_72m);
    bus_addr = 16'($urandom); bus_sltsl_n = 1'b0; bus_mreq_n = 1'b0; bus_rfsh_n = 1'b0; bus_rd_n = 1'b0;
    repeat (5) begin
      @(negedge clk_72m);
      n += int'(a_rd) + int'(a_wr) + int'(a_acc) + int'(b_rd) + int'(c_rd);
    end
    bus_rd_n = 1'b1; bus_wr_n = 1'b0;
    repeat (5) begin
      @(negedge clk_72m);
      n += int'(a_rd) + int'(a_wr) + int'(a_acc) + int'(b_wr) + int'(c_wr);
    end
    bus_idle();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL refresh: got %0d request cycles, expected 0", n);
    end
  endtask

  task automatic test_reset_abort();
    int seen, n;
    seen = 0; n = 0;
    io_write(3, 8'($urandom_range(1, 255)));
    @(negedge clk_72m);
    bus_addr = 16'($urandom); psram_dout = 16'($urandom); psram_busy = 1'b0;
    bus_sltsl_n = 1'b0; bus_mreq_n = 1'b0; bus_rd_n = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk_72m);
      if (a_rd) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL abort_setup: got no psram_read within 20 cycles, expected one");
    end
    psram_busy = 1'b1;
    repeat (3) @(negedge clk_72m);
    checks++;
    if (a_oe || b_oe || c_oe) begin
      errors++;
      $display("FAIL oe_in_wait: got oe=%b%b%b, expected 000", a_oe, b_oe, c_oe);
    end
    reset = 1'b1; bus_idle();
    @(negedge clk_72m);
    mreg = '{3, 2, 1, 0};
    check_idle_outputs("abort");
    checks++;
    if (a_addr !== 22'd0 || a_dout !== 8'd0) begin
      errors++;
      $display("FAIL abort_data: got addr=%h dout=%h, expected 0/0", a_addr, a_dout);
    end
    check_segs("abort");
    reset = 1'b0; psram_busy = 1'b0;
    repeat (10) begin
      @(negedge clk_72m);
      n += int'(a_rd) + int'(a_wr) + int'(a_oe) + int'(b_rd) + int'(c_rd);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles after reset, expected 0", n);
    end
  endtask

  task automatic test_random();
    int op;
    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        io_write(int'($urandom_range(0, 3)), 8'($urandom));
        check_segs("rand_write");
      end else if (op == 1) begin
        mem_access(1'($urandom), 16'($urandom), 8'($urandom), 16'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
      end else begin
        io_read(int'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_init();
    test_edge_write();
    test_refresh();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
